atmos_light_topk: RTL and testbench
===================================

ATMOS_LIGHT_TOPK -- requirements
Module: atmos_light_topk

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel/dark-channel width.
REQ-002 SHALL have parameter IMG_HDISP, default 1024, active pixels per line.
REQ-003 SHALL have parameter IMG_VDISP, default 768, active lines per frame.
REQ-004 SHALL have parameter TOP_K, default 8, candidate count (power of two, 2..64).
REQ-005 SHALL have parameter A_MAX, default 240, upper clamp on the frame estimate.
REQ-006 SHALL have parameter IIR_SHIFT, default 2, temporal smoothing shift (0 disables smoothing).
REQ-007 SHALL have port clk, input, 1, single clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports per_frame_vsync / per_frame_href / per_frame_clken, input, 1 each, frame sync, line valid, pixel strobe.
REQ-010 SHALL have ports per_img_dark / per_img_red / per_img_green / per_img_blue, input, DATA_W each, dark channel and colour of the current pixel.
REQ-011 SHALL have port atmospheric_light, output, DATA_W, smoothed atmospheric light.
REQ-012 SHALL have ports atmospheric_pos_x / atmospheric_pos_y, output, 11 each, coordinates of the rank-0 (darkest-channel-maximum) candidate.
REQ-013 SHALL have port atmos_valid, output, 1, one-cycle pulse when outputs update; port busy, output, 1, high during AVERAGE/FILTER.

Function
REQ-014 SHALL count x (0..IMG_HDISP-1) and y (0..IMG_VDISP-1) on per_frame_clken, wrapping x into y, y to 0 after the last pixel.
REQ-015 SHALL treat a per_frame_vsync rising edge as frame abort: x, y and the candidate list cleared; outputs and state unchanged.
REQ-016 SHALL keep a TOP_K list sorted descending by dark value; each entry holds dark, maxRGB = max(R,G,B), x, y, valid.
REQ-017 SHALL insert a strobed pixel at the first rank whose entry is invalid or has dark strictly less than the pixel's; lower entries shift down one, last entry is dropped; equal dark never displaces (earliest pixel wins).
REQ-018 SHALL complete each insertion in the strobe cycle, so back-to-back strobes every cycle are accepted.
REQ-019 SHALL, on the strobe of pixel (IMG_HDISP-1, IMG_VDISP-1) (frame end, cycle F), insert that pixel and, at the same edge, snapshot all maxRGB values and rank-0 x/y into shadow registers, clear the live list, and enter AVERAGE.
REQ-020 SHALL use FSM states IDLE -> AVERAGE (TOP_K cycles, one shadow entry summed per cycle, sum width DATA_W+log2(TOP_K)) -> FILTER (1 cycle) -> IDLE.
REQ-021 SHALL compute avg = sum >> log2(TOP_K) (truncate), then clamp avg to A_MAX.
REQ-022 SHALL in FILTER load atmospheric_light = clamped avg on the first completed frame after reset or when IIR_SHIFT=0; otherwise A <= A + ((avg - A) >>> IIR_SHIFT) in signed DATA_W+1 arithmetic.
REQ-023 SHALL update atmospheric_pos_x/y from the shadow and pulse atmos_valid at the FILTER-exit edge; latency from frame-end strobe to atmos_valid high = TOP_K+2 cycles.
REQ-024 SHALL continue collecting the next frame into the live list while AVERAGE/FILTER run; a vsync abort during AVERAGE/FILTER does not disturb the computation.

Reset
REQ-025 SHALL on rst_n low clear counters, list, shadow, FSM to IDLE, atmospheric_light/pos_x/pos_y to 0, atmos_valid and busy to 0, first-frame flag set.
REQ-026 SHALL, on reset mid-AVERAGE, discard the computation and emit no atmos_valid.

Structure
REQ-027 SHALL place FSM state encoding and the coordinate width (11) in the shared ISP package.
REQ-028 SHALL implement the sorted list as sub-module topk_sorted_list (insert, clear, parallel read-out).

Verification
REQ-029 SHALL test: 8x4 image, TOP_K=4, all dark=0 except pixel (5,2) dark=200 RGB=(180,220,90) -> rank-0 pos (5,2), entries avg of {220,...}; valid at F+6.
REQ-030 SHALL test: dark=100 at pixels 0,1,2,3,4 with maxRGB 10,20,30,40,50 -> list keeps first four, light=25.
REQ-031 SHALL test: four candidates maxRGB=255 -> light clamped to 240.
REQ-032 SHALL test: IIR_SHIFT=2, frame1 avg 200 -> 200; frame2 avg 100 -> 175.
REQ-033 SHALL test: vsync rise at pixel (3,1) then full frame -> result reflects only the full frame.
REQ-034 SHALL test: rst_n low for one cycle during AVERAGE -> no atmos_valid, outputs 0, next full frame loads directly.

Source files
------------

// File: rtl/atmos_light_topk_pkg.sv
// Shared ISP definitions for the atmospheric-light estimator: FSM encoding
// and the pixel-coordinate width.
package atmos_light_topk_pkg;

    localparam int unsigned COORD_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_AVERAGE = 2'd1,
        ST_FILTER  = 2'd2
    } atmos_state_e;

endpackage

// File: rtl/atmos_light_topk_list.sv
// Descending-by-dark TOP_K candidate list with single-cycle insertion, clear,
// and parallel read-out of the list as it stands after this cycle's insertion.
module topk_sorted_list
    import atmos_light_topk_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TOP_K  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ins_i,
    input  logic                           clr_i,
    input  logic [DATA_W-1:0]              dark_i,
    input  logic [DATA_W-1:0]              maxrgb_i,
    input  logic [COORD_W-1:0]             x_i,
    input  logic [COORD_W-1:0]             y_i,
    output logic [TOP_K-1:0][DATA_W-1:0]   rd_maxrgb_o,
    output logic [COORD_W-1:0]             rd_x0_o,
    output logic [COORD_W-1:0]             rd_y0_o
);

    typedef struct packed {
        logic                vld;
        logic [DATA_W-1:0]   dark;
        logic [DATA_W-1:0]   maxrgb;
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
    } entry_t;

    entry_t             list_q   [TOP_K];
    entry_t             list_d   [TOP_K];
    entry_t             ins_list [TOP_K];
    entry_t             pix;
    logic [TOP_K-1:0]   beats;

    // beats[] is monotonic (valid entries are contiguous and sorted), so the
    // insertion rank is the first set bit and every later rank shifts down.
    always_comb begin
        pix = '{vld: 1'b1, dark: dark_i, maxrgb: maxrgb_i, x: x_i, y: y_i};
        for (int unsigned i = 0; i < TOP_K; i++) begin
            beats[i]    = !list_q[i].vld || (list_q[i].dark < dark_i);
            ins_list[i] = list_q[i];
        end
        if (ins_i && beats[0]) begin
            ins_list[0] = pix;
        end
        for (int unsigned i = 1; i < TOP_K; i++) begin
            if (ins_i && beats[i]) begin
                ins_list[i] = beats[i-1] ? list_q[i-1] : pix;
            end
        end
        for (int unsigned i = 0; i < TOP_K; i++) begin
            list_d[i]      = clr_i ? '0 : ins_list[i];
            rd_maxrgb_o[i] = ins_list[i].maxrgb;
        end
        rd_x0_o = ins_list[0].x;
        rd_y0_o = ins_list[0].y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TOP_K; i++) begin
                list_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < TOP_K; i++) begin
                list_q[i] <= list_d[i];
            end
        end
    end

endmodule

// File: rtl/atmos_light_topk.sv
// Atmospheric-light estimator: averages maxRGB of the TOP_K darkest-channel
// maxima of each frame, clamps, and temporally smooths the result.
module atmos_light_topk
    import atmos_light_topk_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IMG_HDISP = 1024,
    parameter int unsigned IMG_VDISP = 768,
    parameter int unsigned TOP_K     = 8,
    parameter int unsigned A_MAX     = 240,
    parameter int unsigned IIR_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                per_frame_vsync,
    input  logic                per_frame_href,
    input  logic                per_frame_clken,
    input  logic [DATA_W-1:0]   per_img_dark,
    input  logic [DATA_W-1:0]   per_img_red,
    input  logic [DATA_W-1:0]   per_img_green,
    input  logic [DATA_W-1:0]   per_img_blue,
    output logic [DATA_W-1:0]   atmospheric_light,
    output logic [COORD_W-1:0]  atmospheric_pos_x,
    output logic [COORD_W-1:0]  atmospheric_pos_y,
    output logic                atmos_valid,
    output logic                busy
);

    localparam int unsigned LOG2K = $clog2(TOP_K);
    localparam int unsigned SUM_W = DATA_W + LOG2K;

    atmos_state_e                 state_q, state_d;
    logic                         vs_q;
    logic [COORD_W-1:0]           x_q, x_d, y_q, y_d;
    logic [LOG2K-1:0]             idx_q, idx_d;
    logic [SUM_W-1:0]             sum_q, sum_d;
    logic [TOP_K-1:0][DATA_W-1:0] shadow_q, shadow_d;
    logic [COORD_W-1:0]           shx_q, shx_d, shy_q, shy_d;
    logic [DATA_W-1:0]            light_q, light_d;
    logic [COORD_W-1:0]           posx_q, posx_d, posy_q, posy_d;
    logic                         valid_q, valid_d;
    logic                         first_q, first_d;

    logic                         vs_rise, stb, last_x, last_y, frame_end;
    logic [DATA_W-1:0]            maxrgb, avg, avg_c, filt;
    logic [SUM_W-1:0]             avg_full;
    logic signed [DATA_W:0]       diff, step;
    logic [TOP_K-1:0][DATA_W-1:0] rd_maxrgb;
    logic [COORD_W-1:0]           rd_x0, rd_y0;

    // A vsync rising edge aborts the frame and takes priority over a strobe.
    assign vs_rise   = per_frame_vsync & ~vs_q;
    assign stb       = per_frame_href & per_frame_clken & ~vs_rise;
    assign last_x    = (x_q == COORD_W'(IMG_HDISP - 1));
    assign last_y    = (y_q == COORD_W'(IMG_VDISP - 1));
    assign frame_end = stb & last_x & last_y;

    always_comb begin
        maxrgb = per_img_red;
        if (per_img_green > maxrgb) maxrgb = per_img_green;
        if (per_img_blue > maxrgb)  maxrgb = per_img_blue;
    end

    topk_sorted_list #(
        .DATA_W (DATA_W),
        .TOP_K  (TOP_K)
    ) u_list (
        .clk         (clk),
        .rst_n       (rst_n),
        .ins_i       (stb),
        .clr_i       (vs_rise | frame_end),
        .dark_i      (per_img_dark),
        .maxrgb_i    (maxrgb),
        .x_i         (x_q),
        .y_i         (y_q),
        .rd_maxrgb_o (rd_maxrgb),
        .rd_x0_o     (rd_x0),
        .rd_y0_o     (rd_y0)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vs_rise) begin
            x_d = '0;
            y_d = '0;
        end else if (stb) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    always_comb begin
        avg_full = sum_q >> LOG2K;
        avg      = avg_full[DATA_W-1:0];
        avg_c    = (avg > DATA_W'(A_MAX)) ? DATA_W'(A_MAX) : avg;
        diff     = $signed({1'b0, avg_c}) - $signed({1'b0, light_q});
        step     = diff >>> IIR_SHIFT;
        filt     = light_q + step[DATA_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        shadow_d = shadow_q;
        shx_d    = shx_q;
        shy_d    = shy_q;
        light_d  = light_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        valid_d  = 1'b0;
        first_d  = first_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_end) begin
                    shadow_d = rd_maxrgb;
                    shx_d    = rd_x0;
                    shy_d    = rd_y0;
                    idx_d    = '0;
                    sum_d    = '0;
                    state_d  = ST_AVERAGE;
                end
            end
            ST_AVERAGE: begin
                sum_d = sum_q + SUM_W'(shadow_q[idx_q]);
                idx_d = idx_q + LOG2K'(1);
                if (idx_q == LOG2K'(TOP_K - 1)) state_d = ST_FILTER;
            end
            ST_FILTER: begin
                light_d = (first_q || (IIR_SHIFT == 0)) ? avg_c : filt;
                posx_d  = shx_q;
                posy_d  = shy_q;
                valid_d = 1'b1;
                first_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vs_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            shadow_q <= '0;
            shx_q    <= '0;
            shy_q    <= '0;
            light_q  <= '0;
            posx_q   <= '0;
            posy_q   <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            vs_q     <= per_frame_vsync;
            x_q      <= x_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            shadow_q <= shadow_d;
            shx_q    <= shx_d;
            shy_q    <= shy_d;
            light_q  <= light_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
        end
    end

    assign atmospheric_light = light_q;
    assign atmospheric_pos_x = posx_q;
    assign atmospheric_pos_y = posy_q;
    assign atmos_valid       = valid_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_atmos_light_topk.sv
// Self-checking bench for atmos_light_topk: 8x4 frames, TOP_K=4, one DUT
// without smoothing and one with IIR_SHIFT=2, sharing the same stimulus.
module tb_atmos_light_topk;

    localparam int H = 8, V = 4, K = 4, NPIX = H * V, LAT = K + 2, AMAX = 240;

    logic clk = 1'b0, rst_n = 1'b0;
    logic vs = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] dk = '0, rr = '0, gg = '0, bb = '0;
    logic [7:0]  l0, l2;
    logic [10:0] x0, y0, x2, y2;
    logic        v0, v2, busy0, busy2;

    atmos_light_topk #(.DATA_W(8), .IMG_HDISP(H), .IMG_VDISP(V), .TOP_K(K),
                       .A_MAX(AMAX), .IIR_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_dark(dk), .per_img_red(rr),
        .per_img_green(gg), .per_img_blue(bb), .atmospheric_light(l0),
        .atmospheric_pos_x(x0), .atmospheric_pos_y(y0), .atmos_valid(v0), .busy(busy0));

    atmos_light_topk #(.DATA_W(8), .IMG_HDISP(H), .IMG_VDISP(V), .TOP_K(K),
                       .A_MAX(AMAX), .IIR_SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_dark(dk), .per_img_red(rr),
        .per_img_green(gg), .per_img_blue(bb), .atmospheric_light(l2),
        .atmospheric_pos_x(x2), .atmospheric_pos_y(y2), .atmos_valid(v2), .busy(busy2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct { int due; int l0; int l2; int x; int y; } exp_t;
    exp_t q[$];
    exp_t me;

    typedef struct {
        int nsp; int idx[4]; int dark[4]; int r[4]; int g[4]; int b[4];
        int l0; int x; int y;
    } vec_t;
    vec_t vt[4];

    int fd[NPIX], fr[NPIX], fg[NPIX], fb[NPIX];
    int a2 = 0;
    bit first2 = 1'b1;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int mx3(input int a, input int b, input int c);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Reference: pick the K largest dark values, earliest pixel first on ties.
    task automatic topk_ref(output int sum, output int r0);
        bit used[NPIX];
        int best;
        sum = 0;
        r0 = 0;
        foreach (used[p]) used[p] = 1'b0;
        for (int rank = 0; rank < K; rank++) begin
            best = -1;
            for (int p = 0; p < NPIX; p++)
                if (!used[p] && (best < 0 || fd[p] > fd[best])) best = p;
            used[best] = 1'b1;
            sum += mx3(fr[best], fg[best], fb[best]);
            if (rank == 0) r0 = best;
        end
    endtask

    // A + floor((avg - A) / 4)
    function automatic int iir(input int a, input int avg);
        int d = avg - a;
        if (d >= 0) return a + d / 4;
        return a - ((-d + 3) / 4);
    endfunction

    task automatic clear_frame();
        for (int p = 0; p < NPIX; p++) begin
            fd[p] = 0; fr[p] = 0; fg[p] = 0; fb[p] = 0;
        end
    endtask

    task automatic load_vec(input int i);
        clear_frame();
        for (int s = 0; s < vt[i].nsp; s++) begin
            fd[vt[i].idx[s]] = vt[i].dark[s];
            fr[vt[i].idx[s]] = vt[i].r[s];
            fg[vt[i].idx[s]] = vt[i].g[s];
            fb[vt[i].idx[s]] = vt[i].b[s];
        end
    endtask

    task automatic rand_frame();
        for (int p = 0; p < NPIX; p++) begin
            fd[p] = 36 * $urandom_range(0, 7);
            fr[p] = $urandom_range(0, 255);
            fg[p] = $urandom_range(0, 255);
            fb[p] = $urandom_range(0, 255);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0; clken = 1'b0;
        end
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vs = 1'b1; href = 1'b0; clken = 1'b0;
        @(negedge clk);
        vs = 1'b0;
    endtask

    task automatic drive_pix(input int p);
        href = 1'b1; clken = 1'b1;
        dk = 8'(fd[p]); rr = 8'(fr[p]); gg = 8'(fg[p]); bb = 8'(fb[p]);
    endtask

    task automatic run_frame(input bit has_exp, input int e0, input int ex,
                             input int ey, input bit gaps);
        int sum, r0, avg;
        exp_t e;
        for (int p = 0; p < NPIX; p++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                href = 1'b1; clken = 1'b0;
            end
            @(negedge clk);
            drive_pix(p);
            if (p == NPIX - 1) begin
                topk_ref(sum, r0);
                avg = sum / K;
                if (avg > AMAX) avg = AMAX;
                e.due = cyc + LAT;
                e.l0  = has_exp ? e0 : avg;
                e.x   = has_exp ? ex : r0 % H;
                e.y   = has_exp ? ey : r0 / H;
                e.l2  = first2 ? avg : iir(a2, avg);
                a2 = e.l2;
                first2 = 1'b0;
                q.push_back(e);
            end
        end
        @(negedge clk);
        href = 1'b0; clken = 1'b0;
    endtask

    task automatic partial_then_abort(input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            drive_pix(p);
        end
        @(negedge clk);
        drive_pix(n);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0; href = 1'b0; clken = 1'b0;
    endtask

    initial begin
        vt[0] = '{nsp: 1, idx: '{21, 0, 0, 0}, dark: '{200, 0, 0, 0}, r: '{180, 0, 0, 0},
                  g: '{220, 0, 0, 0}, b: '{90, 0, 0, 0}, l0: 55, x: 5, y: 2};
        vt[1] = '{nsp: 4, idx: '{0, 1, 2, 3}, dark: '{100, 100, 100, 100}, r: '{10, 20, 30, 40},
                  g: '{0, 0, 0, 0}, b: '{0, 0, 0, 0}, l0: 25, x: 0, y: 0};
        vt[2] = '{nsp: 4, idx: '{7, 12, 20, 31}, dark: '{50, 50, 50, 50}, r: '{0, 0, 0, 0},
                  g: '{255, 255, 255, 255}, b: '{0, 0, 0, 0}, l0: 240, x: 7, y: 0};
        vt[3] = '{nsp: 2, idx: '{31, 3, 0, 0}, dark: '{250, 9, 0, 0}, r: '{1, 120, 0, 0},
                  g: '{2, 0, 0, 0}, b: '{77, 0, 0, 0}, l0: 49, x: 7, y: 3};

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("busy0", int'(busy0), int'(q.size() > 0 && cyc >= q[0].due - (LAT - 1) && cyc < q[0].due));
                    chk("busy2", int'(busy2), int'(busy0));
                    if (v0 || v2) begin
                        if (q.size() == 0) begin
                            chk("spurious_valid", int'(v0 | v2), 0);
                        end else begin
                            me = q.pop_front();
                            chk("valid_cycle", cyc, me.due);
                            chk("valid0", int'(v0), 1);
                            chk("valid2", int'(v2), 1);
                            chk("light0", int'(l0), me.l0);
                            chk("light2", int'(l2), me.l2);
                            chk("pos_x0", int'(x0), me.x);
                            chk("pos_y0", int'(y0), me.y);
                            chk("pos_x2", int'(x2), me.x);
                            chk("pos_y2", int'(y2), me.y);
                        end
                    end else if (q.size() > 0 && cyc > q[0].due) begin
                        chk("valid_timeout", cyc, q[0].due);
                        void'(q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_light0", int'(l0), 0);
        chk("rst_light2", int'(l2), 0);
        chk("rst_pos_x0", int'(x0), 0);
        chk("rst_pos_y0", int'(y0), 0);
        chk("rst_valid0", int'(v0), 0);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_valid2", int'(v2), 0);
        chk("rst_busy2", int'(busy2), 0);
        rst_n = 1'b1;

        // Table vectors back to back: each next frame is collected while the
        // previous one is still averaging.
        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            vsync_pulse();
            run_frame(1'b1, vt[i].l0, vt[i].x, vt[i].y, 1'b0);
        end

        repeat (6) begin
            rand_frame();
            vsync_pulse();
            run_frame(1'b0, 0, 0, 0, 1'b1);
        end
        idle(12);

        // Abort at pixel (3,1) carrying a very dark-channel candidate.
        clear_frame();
        fd[2] = 255; fr[2] = 99;
        vsync_pulse();
        partial_then_abort(11);
        load_vec(1);
        run_frame(1'b1, 25, 0, 0, 1'b0);
        idle(12);

        // One-cycle reset while AVERAGE is running.
        load_vec(0);
        vsync_pulse();
        run_frame(1'b1, 55, 5, 2, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        first2 = 1'b1;
        a2 = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(12);
        chk("mid_rst_light0", int'(l0), 0);
        chk("mid_rst_light2", int'(l2), 0);
        chk("mid_rst_pos_x2", int'(x2), 0);
        chk("mid_rst_pos_y2", int'(y2), 0);

        // Smoothing: 200 loads directly after reset, then 100 moves it to 175.
        clear_frame();
        for (int p = 0; p < 4; p++) begin fd[p] = 10; fr[p] = 200; end
        vsync_pulse();
        run_frame(1'b1, 200, 0, 0, 1'b0);
        idle(10);
        chk("iir_frame1", int'(l2), 200);
        for (int p = 0; p < 4; p++) fr[p] = 100;
        vsync_pulse();
        run_frame(1'b1, 100, 0, 0, 1'b0);
        idle(10);
        chk("iir_frame2", int'(l2), 175);
        chk("noiir_frame2", int'(l0), 100);

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
